// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and address type for the register file.
// Default geometry, status counter width, and the default address type.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int COUNT_W        = 16;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: combinational read mux with zero-register masking.
// Ports: mem (array), rd_addr, wr_commit/wr_addr/wr_data (forwarding), rd_data.
// Macro REG_FILE_BYPASS_EN enables write-to-read forwarding.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        wr_commit,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data
);

`ifndef REG_FILE_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{wr_commit, wr_addr, wr_data};
`endif

  always_comb begin
    rd_data = mem[rd_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wr_commit && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
    // Masking last: register 0 reads zero even over a forwarded value.
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file, 1 sync write, 2 comb reads.
// Ports: clk, reset (sync, active-high), write_en/addr/data,
//   read_addr1/2 -> read_data1/2, busy (cycle after a write),
//   write_count (saturating). Macro REG_FILE_BYPASS_EN adds forwarding.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_en,
  input  logic [ADDR_W-1:0]  write_addr,
  input  logic [WIDTH-1:0]   write_data,
  input  logic [ADDR_W-1:0]  read_addr1,
  input  logic [ADDR_W-1:0]  read_addr2,
  output logic [WIDTH-1:0]   read_data1,
  output logic [WIDTH-1:0]   read_data2,
  output logic               busy,
  output logic [COUNT_W-1:0] write_count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        zero_hit;
  logic                        commit;

  assign zero_hit = (ZERO_REG != 0) && (write_addr == '0);
  // Reset discards the write outright, so it never commits.
  assign commit   = write_en && !reset && !zero_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem         <= '0;
      busy        <= 1'b0;
      write_count <= '0;
    end else begin
      busy <= commit;
      if (commit) begin
        mem[write_addr] <= write_data;
        if (write_count != '1) begin
          write_count <= write_count + 1'b1;
        end
      end
    end
  end

  reg_file_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rp1 (
    .mem       (mem),
    .rd_addr   (read_addr1),
    .wr_commit (commit),
    .wr_addr   (write_addr),
    .wr_data   (write_data),
    .rd_data   (read_data1)
  );

  reg_file_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rp2 (
    .mem       (mem),
    .rd_addr   (read_addr2),
    .wr_commit (commit),
    .wr_addr   (write_addr),
    .wr_data   (write_data),
    .rd_data   (read_data2)
  );

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised register file that generalises the single-bit D flip-flop to DEPTH words of WIDTH bits.
- Sits in the simple processor datapath between instruction decode and the ALU.
- One synchronous write port and two combinational read ports.
- Adds write-enable, synchronous clear, optional hardwired-zero register, and a write-count status counter.

Parameters:
- WIDTH, 8, bits per register.
- DEPTH, 8, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- write_en  input  1  write strobe for the current cycle.
- write_addr  input  ADDR_W  destination register index.
- write_data  input  WIDTH  data to write.
- read_addr1  input  ADDR_W  read port 1 index.
- read_addr2  input  ADDR_W  read port 2 index.
- read_data1  output  WIDTH  contents of read_addr1.
- read_data2  output  WIDTH  contents of read_addr2.
- busy  output  1  high for exactly the cycle after a committed write.
- write_count  output  16  number of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (posedge clk with reset=1):
  - All DEPTH registers cleared to 0.
  - busy=0, write_count=0.
  - A concurrent write_en is ignored.
  - Reset asserted mid-sequence discards any write in that cycle; it does not defer it.
- Write (posedge clk, reset=0, write_en=1): mem[write_addr] <= write_data.
  - Latency: visible on read ports in the cycle after the edge (no bypass by default).
  - With ZERO_REG=1 and write_addr=0, the write is suppressed: mem[0] unchanged, write_count not incremented, busy not set.
- Read ports:
  - Purely combinational: read_dataN = mem[read_addrN].
  - With ZERO_REG=1 and read_addrN=0, read_dataN = 0 regardless of array contents.
  - Both ports may address the same register; both return the same value.
- Simultaneous read and write to the same address in one cycle:
  - Read returns the old value until the edge.
  - After the edge it returns the new value (see Optional Feature for the exception).
- busy:
  - Registered: busy <= committed write this cycle.
  - Cleared the following cycle unless another write commits.
  - Back-to-back writes hold busy high continuously.
- write_count:
  - Increments by 1 per committed write.
  - Holds at 16'hFFFF; no wrap.
- Address bounds: ADDR_W exactly covers DEPTH, so out-of-range addresses cannot occur.
- X on write_en while reset=0 is a bench error; RTL behaviour is unspecified.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If write_en=1, the write commits (not reset, not zero-reg), and read_addrN == write_addr, then read_dataN = write_data combinationally in the same cycle.
  - Both ports are forwarded independently.
- Undefined: no forwarding; reads show the pre-edge array contents.
- Macro affects only the read-path muxes; state update and latency are otherwise identical.

Decomposition:
- Shared package reg_file_pkg holds:
  - constants DEFAULT_WIDTH=8, DEFAULT_DEPTH=8, COUNT_W=16;
  - typedef reg_addr_t (logic [ADDR_W-1:0]) for the default configuration.
- One natural sub-module: reg_file_read_port.
  - Instantiated twice.
  - Contains the array select, ZERO_REG masking, and the optional bypass mux.
  - Inputs: array, read address, write-commit signal, write address, write data.
- The write logic, busy flag, and counter stay in the top module.

Test Plan:
- Reset clears:
  - Preload all 8 regs with 8'hA5, assert reset one cycle with write_en=1 to addr 3 and data 8'h11.
  - Every read returns 8'h00, write_count=0, busy=0.
- Write/read latency:
  - Write 8'h3C to addr 5.
  - Read1 at addr 5 shows 8'h3C in the cycle after the edge, busy=1 for one cycle, write_count=1.
  - Same-cycle read shows the old value without REG_FILE_BYPASS_EN and 8'h3C with it.
- Dual ports, same/different addresses:
  - Write 8'h12 to addr 1 and 8'h34 to addr 2.
  - read_addr1=1, read_addr2=2 returns 8'h12/8'h34.
  - Both addresses set to 2 returns 8'h34 on both ports.
- ZERO_REG=1:
  - Write 8'hFF to addr 0.
  - read_data1 at addr 0 stays 8'h00, write_count unchanged, busy stays 0.
- Back-to-back writes and saturation:
  - Ten consecutive writes give busy high for 10 consecutive cycles and write_count=10.
  - Force the count to 16'hFFFE, do 3 writes: write_count=16'hFFFF.
- Reset mid-burst:
  - Writes to addrs 0..3 with reset asserted during the addr 2 cycle.
  - Afterwards all regs are 0, addr 2 was never written, and the addr 3 write lands normally with write_count=1.
